serial_frame_ctrl: RTL
======================

Name: serial_frame_ctrl

Overview:
Transmit-side frame sequencer for the serial link. It owns a 4-bit baud prescale counter and a bit-index counter, the same two-level counter structure as the dual-counter datapath. It accepts one parallel word per valid/ready handshake and serializes it LSB-first as a start bit, DATA_W data bits and STOP_BITS stop bits. It reports busy, the baud tick and a per-frame done pulse to the surrounding serial communication circuit.

Parameters:
- DATA_W, 8: data bits per frame; legal range 5..8.
- PRESCALE, 10: clocks per serial bit; legal range 2..16, held in a 4-bit counter that counts 0..PRESCALE-1.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- tx_data  in  DATA_W  word to send; sampled only on handshake.
- tx_valid  in  1  requester has a word.
- tx_ready  out  1  controller can accept a word.
- tx_out  out  1  serial line; idle level 1.
- busy  out  1  a frame is in progress.
- baud_tick  out  1  one-clock pulse on the last clock of each bit period.
- done  out  1  one-clock pulse on the last clock of the final stop bit.

Behaviour:
- Reset (rst=0 at a clock edge) forces: state IDLE, tx_out=1, tx_ready=1, busy=0, baud_tick=0, done=0, prescale=0, bit index=0, shift register=0.
- Reset overrides everything, including mid-frame. The frame aborts, the line returns to 1 on that edge, and no done pulse is issued.
- States: IDLE, START, DATA, [PARITY], STOP. All outputs are registered.
- IDLE:
  - tx_ready=1, tx_out=1, prescale held at 0.
  - On tx_valid && tx_ready, latch tx_data and go to START; tx_out goes to 0 on that edge.
- Prescaler:
  - Counts 0..PRESCALE-1 in every non-IDLE state.
  - baud_tick=1 when the count equals PRESCALE-1; the count then wraps to 0.
  - Every bit therefore lasts exactly PRESCALE clocks.
- START: on tick, go to DATA with bit index 0 and drive tx_out = shift[0].
- DATA:
  - On each tick, shift right and increment the index.
  - After bit DATA_W-1, go to PARITY if compiled in, otherwise to STOP with tx_out=1.
- STOP:
  - Counts STOP_BITS bit periods.
  - On the tick of the last stop bit, done=1 for that clock, then go to IDLE.
- Handshake and status:
  - busy=1 and tx_ready=0 in every non-IDLE state.
  - tx_valid while busy is ignored; tx_data is not re-sampled mid-frame.
- Latency:
  - The handshake edge starts the start bit.
  - Frame length = (1+DATA_W+STOP_BITS[+1 with parity])*PRESCALE clocks.
  - Back-to-back frames with tx_valid held high are separated by exactly one IDLE clock (tx_out=1), in which the next handshake occurs.
- Parameter guard: a PRESCALE outside 2..16 or an illegal DATA_W/STOP_BITS is an elaboration error.

Optional Feature:
- Macro: SERIAL_FRAME_PARITY_EN.
- Defined: a PARITY state of one bit period is inserted between DATA and STOP. tx_out carries even parity, the XOR of the latched data bits.
- Undefined: no PARITY state, and the frame length formula omits the +1.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and the 3-bit state width;
  - the idle line level constant (1);
  - the PRESCALE width constant (4).
- One natural sub-module: baud_prescaler, the 4-bit 0..PRESCALE-1 counter with enable. It produces baud_tick and clears to 0 when disabled or in reset.

Test Plan:
1. Reset: hold rst=0 for 3 clocks with tx_valid=1 -> tx_out=1, tx_ready=1, busy=0, done=0; no frame starts.
2. Single frame, PRESCALE=4, DATA_W=8, parity off, tx_data=0xA5 -> tx_out per 4-clock period = 0,1,0,1,0,0,1,0,1,1; done pulses exactly 40 clocks after the handshake edge; busy is high for 40 clocks.
3. Back-to-back: tx_valid held high with 0x3C then 0xFF -> the second handshake occurs in the single IDLE clock after done; the second start bit begins 41 clocks after the first.
4. Busy ignore: pulse tx_valid with 0x00 at clock 10 of a 0xA5 frame -> the serialized bits remain 0xA5 and no extra frame is sent.
5. Reset mid-frame: rst=0 during data bit 3 -> tx_out=1 and tx_ready=1 at the next edge, with no done pulse; a new 0x5A frame afterwards is correct.
6. SERIAL_FRAME_PARITY_EN defined:
   - 0xA5 -> parity bit 0, frame length 44 clocks at PRESCALE=4.
   - 0x07 -> parity bit 1.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and state encoding for the serial frame controller.
// Contents: STATE_W state width, PRE_W prescaler width, IDLE_LVL idle line level, state_t FSM encoding.
package serial_pkg;
    localparam int STATE_W = 3;
    localparam int PRE_W = 4;
    localparam logic IDLE_LVL = 1'b1;
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
endpackage

// File: rtl/serial_frame_ctrl_if.sv
// serial_frame_ctrl_if: transmit handshake and status bundle of the serial frame controller.
// Signals: tx_data/tx_valid (requester -> controller), tx_ready/tx_out/busy/baud_tick/done (controller -> requester).
// Modports: master = requester side, slave = controller side.
interface serial_frame_ctrl_if #(parameter int DATA_W = 8) ();
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_out;
    logic              busy;
    logic              baud_tick;
    logic              done;
    modport master (output tx_data, tx_valid, input tx_ready, tx_out, busy, baud_tick, done);
    modport slave  (input tx_data, tx_valid, output tx_ready, tx_out, busy, baud_tick, done);
endinterface

// File: rtl/baud_prescaler.sv
// baud_prescaler: 4-bit 0..PRESCALE-1 bit-period counter with enable.
// Ports: clk, rst (sync, active-low), en (count enable; clears when low),
//        cnt (current count), tick (registered, high while cnt == PRESCALE-1).
module baud_prescaler
    import serial_pkg::*;
#(
    parameter int PRESCALE = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [PRE_W-1:0] cnt,
    output logic             tick
);
    localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);
    // tick is registered one count early so it lines up with cnt == LAST
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (en && cnt != LAST) ? cnt + 1'b1 : '0;
            tick <= en && (cnt == LAST - 1'b1);
        end
    end
endmodule

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: transmit frame sequencer, LSB-first start/data/[parity]/stop serializer.
// Ports: clk, rst (sync, active-low), bus (serial_frame_ctrl_if.slave: tx_data, tx_valid,
//        tx_ready, tx_out, busy, baud_tick, done).
// Option: define SERIAL_FRAME_PARITY_EN to insert an even-parity bit between data and stop.
module serial_frame_ctrl
    import serial_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PRESCALE  = 10,
    parameter int STOP_BITS = 1
) (
    input logic                clk,
    input logic                rst,
    serial_frame_ctrl_if.slave bus
);
    if (DATA_W < 5 || DATA_W > 8 || PRESCALE < 2 || PRESCALE > 16 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
        $error("serial_frame_ctrl: illegal DATA_W/PRESCALE/STOP_BITS");
    end

    localparam logic [2:0]       LAST_D   = 3'(DATA_W - 1);
    localparam logic [2:0]       LAST_S   = 3'(STOP_BITS - 1);
    localparam logic [PRE_W-1:0] PRE_DONE = PRE_W'(PRESCALE - 2);

    state_t            state, state_d;
    logic [DATA_W-1:0] shift, shift_d;
    logic [2:0]        idx, idx_d;
    logic [PRE_W-1:0]  cnt;
    logic              tick, hs, post_data;
    logic              tx_out_q, tx_out_d, ready_q, busy_q, done_q, done_d;

    assign hs = ready_q && bus.tx_valid;

`ifdef SERIAL_FRAME_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par;
    always_ff @(posedge clk) begin
        if (!rst) par <= 1'b0;
        else if (hs) par <= ^bus.tx_data;
    end
    assign post_data = par;
`else
    localparam state_t AFTER_DATA = STOP;
    assign post_data = IDLE_LVL;
`endif

    baud_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .cnt  (cnt),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            shift    <= '0;
            idx      <= '0;
            tx_out_q <= IDLE_LVL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            shift    <= shift_d;
            idx      <= idx_d;
            tx_out_q <= tx_out_d;
            ready_q  <= state_d == IDLE;
            busy_q   <= state_d != IDLE;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = hs ? START : IDLE;
            START:   state_d = tick ? DATA : START;
            DATA:    state_d = (tick && idx == LAST_D) ? AFTER_DATA : DATA;
            PARITY:  state_d = tick ? STOP : PARITY;
            STOP:    state_d = (tick && idx == LAST_S) ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // shift[0] is the bit on the line during DATA, so the next data bit is shift[1];
    // done is registered one count ahead so it coincides with the final stop-bit tick
    always_comb begin
        shift_d  = hs ? bus.tx_data : (state == DATA && tick) ? shift >> 1 : shift;
        idx_d    = (state_d != state) ? '0 : tick ? idx + 1'b1 : idx;
        tx_out_d = hs ? 1'b0 : !tick ? tx_out_q : (state == START) ? shift[0] :
                   (state == DATA && state_d == DATA) ? shift[1] :
                   (state == DATA) ? post_data : IDLE_LVL;
        done_d   = state == STOP && idx == LAST_S && cnt == PRE_DONE;
    end

    assign bus.tx_out    = tx_out_q;
    assign bus.tx_ready  = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.baud_tick = tick;
endmodule
